// File: rtl/fir_pkg.sv
// Shared constants and types for the delay-tap FIR stages.
package fir_pkg;

   localparam int unsigned TAP_COUNT = 5;
   localparam int unsigned SAMPLE_W  = 8;
   localparam int unsigned COEF_W    = 8;
   localparam int unsigned COEF_FRAC = 6;
   localparam int unsigned PROD_W    = SAMPLE_W + COEF_W;
   localparam int unsigned ACC_W     = 19;
   localparam int unsigned FILL_LEN  = 20;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [COEF_W-1:0]   coef_t;
   typedef logic signed [PROD_W-1:0]   prod_t;
   typedef logic signed [PROD_W:0]     psum_t;
   typedef logic signed [ACC_W-1:0]    acc_t;

   // Q2.6 unity and zero coefficients; reset leaves a pass-through of x[n].
   localparam coef_t COEF_UNITY = 8'sh40;
   localparam coef_t COEF_ZERO  = 8'sh00;

   function automatic coef_t coef_default(input int unsigned idx);
      return (idx == 0) ? COEF_UNITY : COEF_ZERO;
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round half-up (toward +inf) by COEF_FRAC bits, then clamp to the signed sample range.
module fir_round_sat
   import fir_pkg::*;
(
   input  logic signed [fir_pkg::ACC_W-1:0]    acc,
   output logic signed [fir_pkg::SAMPLE_W-1:0] y
);

   localparam acc_t ROUND_BIAS = acc_t'(1 << (COEF_FRAC - 1));
   localparam acc_t SAT_MAX    = acc_t'((2 ** (SAMPLE_W - 1)) - 1);
   localparam acc_t SAT_MIN    = acc_t'(-(2 ** (SAMPLE_W - 1)));

   acc_t biased;
   acc_t shifted;

   // Bias, arithmetic shift, clamp; headroom in ACC_W keeps the bias add from wrapping.
   always_comb begin
      biased  = acc + ROUND_BIAS;
      shifted = biased >>> COEF_FRAC;
      if (shifted > SAT_MAX) begin
         y = SAT_MAX[SAMPLE_W-1:0];
      end else if (shifted < SAT_MIN) begin
         y = SAT_MIN[SAMPLE_W-1:0];
      end else begin
         y = shifted[SAMPLE_W-1:0];
      end
   end

endmodule

// File: rtl/delay_tap_fir5.sv
// Five-tap FIR over delay-line taps 0/5/10/15/20 with loadable Q2.6 coefficients.
module delay_tap_fir5 #(
   parameter int unsigned LATENCY  = 3,
   parameter int unsigned FILL_LEN = fir_pkg::FILL_LEN
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                shift,
   input  logic signed [fir_pkg::SAMPLE_W-1:0] x0,
   input  logic signed [fir_pkg::SAMPLE_W-1:0] x5,
   input  logic signed [fir_pkg::SAMPLE_W-1:0] x10,
   input  logic signed [fir_pkg::SAMPLE_W-1:0] x15,
   input  logic signed [fir_pkg::SAMPLE_W-1:0] x20,
   input  logic                                coef_we,
   input  logic [2:0]                          coef_addr,
   input  logic signed [fir_pkg::COEF_W-1:0]   coef_data,
   output logic signed [fir_pkg::SAMPLE_W-1:0] y,
   output logic                                y_valid
);

   import fir_pkg::*;

   localparam int unsigned FILL_W = $clog2(FILL_LEN + 1);

   sample_t             tap [TAP_COUNT];
   coef_t               coef [TAP_COUNT];
   prod_t               prod_q [TAP_COUNT];
   psum_t               sum01_q;
   psum_t               sum23_q;
   prod_t               prod4_q;
   acc_t                acc_sum;
   sample_t             sat_val;
   logic [FILL_W-1:0]   fill_cnt;
   logic                filled;
   logic [LATENCY-1:0]  tag_pipe;

   // Gather the taps into an indexable array.
   always_comb begin
      tap[0] = x0;
      tap[1] = x5;
      tap[2] = x10;
      tap[3] = x15;
      tap[4] = x20;
   end

   // Coefficient bank: writes land at the end of the write cycle; addresses 5..7 are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < TAP_COUNT; i++) begin
            coef[i] <= coef_default(i);
         end
      end else if (coef_we) begin
         case (coef_addr)
            3'd0:    coef[0] <= coef_data;
            3'd1:    coef[1] <= coef_data;
            3'd2:    coef[2] <= coef_data;
            3'd3:    coef[3] <= coef_data;
            3'd4:    coef[4] <= coef_data;
            default: ;
         endcase
      end
   end

   assign filled = (fill_cnt == FILL_W'(FILL_LEN));

   // Fill counter: counts accepted shifts, saturating once the oldest tap is real data.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt <= '0;
      end else if (shift && !filled) begin
         fill_cnt <= fill_cnt + 1'b1;
      end
   end

   // Valid tag travels alongside the data; the last bit is the output flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_pipe <= '0;
      end else begin
         tag_pipe <= {tag_pipe[LATENCY-2:0], shift && filled};
      end
   end

   assign y_valid = tag_pipe[LATENCY-1];

   // Stage 1: products of the pre-shift taps with the current coefficients.
   always_ff @(posedge clk) begin
      if (shift && !rst) begin
         for (int unsigned i = 0; i < TAP_COUNT; i++) begin
            prod_q[i] <= tap[i] * coef[i];
         end
      end
   end

   // Stage 2: pairwise partial sums.
   always_ff @(posedge clk) begin
      sum01_q <= psum_t'(prod_q[0]) + psum_t'(prod_q[1]);
      sum23_q <= psum_t'(prod_q[2]) + psum_t'(prod_q[3]);
      prod4_q <= prod_q[4];
   end

   // Final sum: worst case 5 * 128 * 128 fits in ACC_W with margin.
   always_comb begin
      acc_sum = acc_t'(sum01_q) + acc_t'(sum23_q) + acc_t'(prod4_q);
   end

   fir_round_sat u_round_sat (
      .acc (acc_sum),
      .y   (sat_val)
   );

   // Stage 3: capture the rounded result only for tagged samples so y holds between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         y <= '0;
      end else if (tag_pipe[LATENCY-2]) begin
         y <= sat_val;
      end
   end

endmodule

// File: tb/tb_delay_tap_fir5.sv
// Directed, table-driven bench for delay_tap_fir5.
module tb_delay_tap_fir5;

   logic              clk = 1'b0;
   logic              rst;
   logic              shift;
   logic signed [7:0] x0, x5, x10, x15, x20;
   logic              coef_we;
   logic [2:0]        coef_addr;
   logic signed [7:0] coef_data;
   logic signed [7:0] y;
   logic              y_valid;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [7:0] h0, h1, h2, h3, h4;
      logic [7:0] v0, v5, v10, v15, v20;
      logic [7:0] exp_y;
   } vec_t;

   vec_t vec [10];

   delay_tap_fir5 #(.LATENCY(3), .FILL_LEN(20)) dut (
      .clk       (clk),
      .rst       (rst),
      .shift     (shift),
      .x0        (x0),
      .x5        (x5),
      .x10       (x10),
      .x15       (x15),
      .x20       (x20),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .y         (y),
      .y_valid   (y_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic write_coef(input logic [2:0] addr, input logic [7:0] data);
      coef_we   = 1'b1;
      coef_addr = addr;
      coef_data = data;
      tick();
      coef_we   = 1'b0;
   endtask

   task automatic set_taps(input logic [7:0] a, b, c, d, e);
      x0 = a; x5 = b; x10 = c; x15 = d; x20 = e;
   endtask

   // Shift every cycle for n samples with x0 = c; with default coefficients y must equal x0.
   // After the tick at edge c, the output reflects sample c-2; the first tagged sample is 21.
   task automatic ramp(input int n);
      for (int c = 1; c <= n + 3; c++) begin
         shift = (c <= n);
         set_taps(8'(c), 8'(c + 40), 8'(c + 80), 8'(-c), 8'(c + 7));
         tick();
         if ((c - 2) >= 21 && (c - 2) <= n) begin
            check("ramp_valid", int'(y_valid), 1);
            check("ramp_y", int'(y), c - 2);
         end else begin
            check("ramp_no_valid", int'(y_valid), 0);
         end
      end
      shift = 1'b0;
   endtask

   initial begin
      rst = 1'b1; shift = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      set_taps(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

      // h0..h4, x0..x20, expected y
      vec[0] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd50};
      vec[1] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
      vec[2] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      vec[3] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'd3, 8'd100, 8'd100, 8'd100, 8'd100, 8'd2};
      vec[4] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 8'd100, 8'd100, 8'd100, 8'd100, 8'hFF};
      vec[5] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'd1, 8'd100, 8'd100, 8'd100, 8'd100, 8'd1};
      vec[6] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd100, 8'd100, 8'd100, 8'd100, 8'd0};
      vec[7] = '{8'h40, 8'hC0, 8'h20, 8'h00, 8'h10, 8'd50, 8'd20, 8'hD8, 8'd99, 8'd8, 8'd12};
      vec[8] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'd1, 8'd1, 8'd1, 8'd1, 8'h80};
      vec[9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'd5, 8'd5, 8'd5, 8'd5, 8'hE0, 8'hE0};

      tick();
      tick();
      rst = 1'b0;
      check("reset_y", int'(y), 0);
      check("reset_valid", int'(y_valid), 0);

      // Default coefficients pass x[n] through; first pulse for the 21st shift.
      ramp(30);

      // Fill counter is saturated now; each vector is a single isolated sample.
      foreach (vec[i]) begin
         write_coef(3'd0, vec[i].h0);
         write_coef(3'd1, vec[i].h1);
         write_coef(3'd2, vec[i].h2);
         write_coef(3'd3, vec[i].h3);
         write_coef(3'd4, vec[i].h4);
         shift = 1'b1;
         set_taps(vec[i].v0, vec[i].v5, vec[i].v10, vec[i].v15, vec[i].v20);
         tick();
         shift = 1'b0;
         tick();
         check($sformatf("vec%0d_early", i), int'(y_valid), 0);
         tick();
         check($sformatf("vec%0d_valid", i), int'(y_valid), 1);
         check($sformatf("vec%0d_y", i), int'(y), int'($signed(vec[i].exp_y)));
         tick();
         check($sformatf("vec%0d_pulse_end", i), int'(y_valid), 0);
         check($sformatf("vec%0d_hold", i), int'(y), int'($signed(vec[i].exp_y)));
      end

      // Coefficient write in the same cycle as a shift applies from the next sample.
      write_coef(3'd0, 8'h40);
      write_coef(3'd1, 8'h00);
      write_coef(3'd2, 8'h00);
      write_coef(3'd3, 8'h00);
      write_coef(3'd4, 8'h00);
      shift = 1'b1;
      set_taps(8'd10, 8'd20, 8'd0, 8'd0, 8'd0);
      coef_we = 1'b1; coef_addr = 3'd1; coef_data = 8'h40;
      tick();
      coef_we = 1'b0;
      tick();
      shift = 1'b0;
      tick();
      check("samecyc_old_valid", int'(y_valid), 1);
      check("samecyc_old_y", int'(y), 10);
      tick();
      check("samecyc_new_valid", int'(y_valid), 1);
      check("samecyc_new_y", int'(y), 30);
      tick();

      // Back-to-back writes to one address: last wins. Addresses 5..7 change nothing.
      write_coef(3'd0, 8'h00);
      write_coef(3'd1, 8'h00);
      write_coef(3'd2, 8'h10);
      write_coef(3'd2, 8'h40);
      for (int a = 5; a <= 7; a++) write_coef(3'(a), 8'h7F);
      shift = 1'b1;
      set_taps(8'd5, 8'd7, 8'd9, 8'd11, 8'd13);
      tick();
      shift = 1'b0;
      tick();
      tick();
      check("lastwrite_valid", int'(y_valid), 1);
      check("lastwrite_y", int'(y), 9);

      // Reset with two samples in flight; shift and coef_we in the reset cycle are ignored.
      shift = 1'b1;
      set_taps(8'd60, 8'd1, 8'd1, 8'd1, 8'd1);
      tick();
      set_taps(8'd61, 8'd1, 8'd1, 8'd1, 8'd1);
      tick();
      rst = 1'b1;
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'h10;
      tick();
      rst = 1'b0; shift = 1'b0; coef_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("flush_no_valid", int'(y_valid), 0);
         check("flush_y_reset", int'(y), 0);
         tick();
      end

      // Twenty fresh shifts before a valid output, and coefficients back to defaults.
      ramp(25);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
